ecc_secded_pipe: RTL and testbench

ECC_SECDED_PIPE -- requirements
Module: ecc_secded_pipe

---
 rtl/ecc_pkg.sv | 32 +++
 rtl/ecc_syndrome.sv | 23 ++
 rtl/ecc_secded_pipe.sv | 148 ++++++++++++++
 tb/tb_ecc_secded_pipe.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ecc_pkg.sv
// Purpose: shared types and helpers for the SECDED decode pipeline.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: calc_pw (parity bit count for a data width), data_pos (codeword
// index of a data bit), ecc_status_t (per-result error flags).
package ecc_pkg;

  // Number of Hamming parity bits needed to cover dw data bits.
  function automatic int calc_pw(input int dw);
    return $clog2(1 + dw + $clog2(1 + dw));
  endfunction

  // 0-based codeword index of data bit i: data fills the 1-based positions
  // that are not powers of two, in ascending order.
  function automatic int data_pos(input int i);
    int cnt;
    cnt = 0;
    data_pos = 0;
    for (int pos = 1; pos <= 2 * i + 3; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        if (cnt == i) data_pos = pos - 1;
        cnt++;
      end
    end
  endfunction

  typedef struct packed {
    logic sec;
    logic ded;
  } ecc_status_t;

endpackage

// File: rtl/ecc_syndrome.sv
// Purpose: combinational Hamming syndrome and overall parity of a codeword.
// Latency: 0 cycles (pure logic).
// Backpressure: none, no handshake.
// Ports: code (DW+PW+1 bit codeword) -> syn (PW bits), par (1 bit).
module ecc_syndrome import ecc_pkg::*; #(
  parameter int DW = 64,
  parameter int PW = calc_pw(DW)
) (
  input  logic [DW+PW:0] code,
  output logic [PW-1:0]  syn,
  output logic           par
);

  // syn is the XOR of the 1-based positions of every set Hamming bit.
  always_comb begin
    syn = '0;
    for (int j = 1; j <= DW + PW; j++) begin
      if (code[j-1]) syn = syn ^ PW'(j);
    end
    par = ^code;
  end

endmodule

// File: rtl/ecc_secded_pipe.sv
// Purpose: two-stage SECDED decoder with saturating SEC/DED event counters.
// Latency: 2 cycles from input transfer to out_valid when not stalled.
// Backpressure: both stages advance only when !out_valid || out_ready; in_ready mirrors that.
// Ports: clk, rst_n (async active-low); in_valid/in_ready/in_code input handshake;
//   out_valid/out_ready/out_data/out_sec/out_ded result handshake;
//   cnt_clr, cnt_sec, cnt_ded error counters.
// Build option: define ECC_ERR_INJECT_EN to add inj_arm/inj_mask one-shot error injection.
module ecc_secded_pipe import ecc_pkg::*; #(
  parameter int DW    = 64,
  parameter int PW    = calc_pw(DW),
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef ECC_ERR_INJECT_EN
  input  logic             inj_arm,
  input  logic [DW+PW:0]   inj_mask,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW+PW:0]   in_code,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_data,
  output logic             out_sec,
  output logic             out_ded,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] cnt_sec,
  output logic [CNT_W-1:0] cnt_ded
);

  localparam int CW = DW + PW + 1;
  localparam int NB = DW + PW;  // Hamming-coded bits, excluding overall parity

  logic          adv;
  logic [CW-1:0] code_in;
  logic [PW-1:0] syn_d;
  logic          par_d;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

`ifdef ECC_ERR_INJECT_EN
  logic [CW-1:0] inj_q;

  assign code_in = in_code ^ inj_q;

  // A fresh arm takes priority; otherwise the mask is consumed by the next accepted word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inj_q <= '0;
    end else if (inj_arm) begin
      inj_q <= inj_mask;
    end else if (in_valid && adv) begin
      inj_q <= '0;
    end
  end
`else
  assign code_in = in_code;
`endif

  ecc_syndrome #(.DW(DW), .PW(PW)) u_syn (
    .code (code_in),
    .syn  (syn_d),
    .par  (par_d)
  );

  // Stage 1: codeword plus its syndrome and parity.
  logic          s1_vld;
  logic [CW-1:0] s1_code;
  logic [PW-1:0] s1_syn;
  logic          s1_par;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld  <= 1'b0;
      s1_code <= '0;
      s1_syn  <= '0;
      s1_par  <= 1'b0;
    end else if (adv) begin
      s1_vld  <= in_valid;
      s1_code <= code_in;
      s1_syn  <= syn_d;
      s1_par  <= par_d;
    end
  end

  // Classify and correct. A syndrome beyond the last coded position with odd
  // parity cannot be a single flip, so it is treated as uncorrectable.
  ecc_status_t   st;
  logic [CW-1:0] fixed;
  logic [DW-1:0] data_d;

  always_comb begin
    st    = '0;
    fixed = s1_code;
    if (s1_par) begin
      if (s1_syn == '0) begin
        st.sec = 1'b1;
      end else if (int'(s1_syn) <= NB) begin
        st.sec = 1'b1;
        fixed  = s1_code ^ (CW'(1) << (s1_syn - PW'(1)));
      end else begin
        st.ded = 1'b1;
      end
    end else if (s1_syn != '0) begin
      st.ded = 1'b1;
    end
  end

  always_comb begin
    data_d = '0;
    for (int i = 0; i < DW; i++) data_d[i] = fixed[data_pos(i)];
  end

  // Stage 2: registered result; bubbles clear the flags so they never count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sec   <= 1'b0;
      out_ded   <= 1'b0;
    end else if (adv) begin
      out_valid <= s1_vld;
      out_data  <= data_d;
      out_sec   <= s1_vld && st.sec;
      out_ded   <= s1_vld && st.ded;
    end
  end

  logic sec_inc, ded_inc;
  assign sec_inc = adv && s1_vld && st.sec;
  assign ded_inc = adv && s1_vld && st.ded;

  // Clear beats a same-cycle increment; counters stick at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_sec <= '0;
      cnt_ded <= '0;
    end else begin
      if (cnt_clr)                      cnt_sec <= '0;
      else if (sec_inc && cnt_sec != '1) cnt_sec <= cnt_sec + CNT_W'(1);
      if (cnt_clr)                      cnt_ded <= '0;
      else if (ded_inc && cnt_ded != '1) cnt_ded <= cnt_ded + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ecc_secded_pipe.sv
// Purpose: scoreboard bench for ecc_secded_pipe at DW=8 (13-bit codeword), CNT_W=3.
// Expected results come from an encoder plus a flip-count rule: 0 flips clean,
// 1 flip corrected, 2 flips uncorrectable with raw data.
module tb_ecc_secded_pipe;
  localparam int DW    = 8;
  localparam int PW    = 4;
  localparam int CW    = DW + PW + 1;
  localparam int CNT_W = 3;
  localparam int CMAX  = 7;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [CW-1:0]    in_code = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [DW-1:0]    out_data;
  logic             out_sec, out_ded;
  logic             cnt_clr = 1'b0;
  logic [CNT_W-1:0] cnt_sec, cnt_ded;
`ifdef ECC_ERR_INJECT_EN
  logic             inj_arm = 1'b0;
  logic [CW-1:0]    inj_mask = '0;
`endif

  typedef struct {
    logic [DW-1:0] data;
    logic          sec;
    logic          ded;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   m_sec = 0;
  int   m_ded = 0;
  int   cycles = 0;
  bit   rand_ready = 0;

  ecc_secded_pipe #(.DW(DW), .PW(PW), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef ECC_ERR_INJECT_EN
    .inj_arm   (inj_arm),
    .inj_mask  (inj_mask),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_code   (in_code),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sec   (out_sec),
    .out_ded   (out_ded),
    .cnt_clr   (cnt_clr),
    .cnt_sec   (cnt_sec),
    .cnt_ded   (cnt_ded)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycles++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit is_pow2(input int v);
    return (v & (v - 1)) == 0;
  endfunction

  function automatic logic [CW-1:0] encode(input logic [DW-1:0] d);
    logic [CW-1:0] c;
    int k;
    c = '0;
    k = 0;
    for (int pos = 1; pos <= CW - 1; pos++) begin
      if (!is_pow2(pos)) begin
        c[pos-1] = d[k];
        k++;
      end
    end
    for (int i = 0; i < PW; i++) begin
      logic b;
      b = 1'b0;
      for (int pos = 1; pos <= CW - 1; pos++) begin
        if (pos[i] && !is_pow2(pos)) b = b ^ c[pos-1];
      end
      c[(1 << i) - 1] = b;
    end
    c[CW-1] = ^c[CW-2:0];
    return c;
  endfunction

  function automatic logic [DW-1:0] extract(input logic [CW-1:0] c);
    logic [DW-1:0] d;
    int k;
    d = '0;
    k = 0;
    for (int pos = 1; pos <= CW - 1; pos++) begin
      if (!is_pow2(pos)) begin
        d[k] = c[pos-1];
        k++;
      end
    end
    return d;
  endfunction

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; the handshake is judged at the next falling edge.
  task automatic send_raw(input logic [CW-1:0] code, input exp_t e);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_code  = code;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", n);
    end else begin
      q.push_back(e);
      if (e.sec && m_sec < CMAX) m_sec++;
      if (e.ded && m_ded < CMAX) m_ded++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_flip(input logic [DW-1:0] d, input logic [CW-1:0] m);
    logic [CW-1:0] c;
    exp_t e;
    c = encode(d) ^ m;
    case ($countones(m))
      0:       e = '{d, 1'b0, 1'b0};
      1:       e = '{d, 1'b1, 1'b0};
      default: e = '{extract(c), 1'b0, 1'b1};
    endcase
    send_raw(c, e);
  endtask

  task automatic send_rand(input int max_flips);
    logic [CW-1:0] m;
    int nf, p1, p2;
    m  = '0;
    nf = $urandom_range(0, max_flips);
    p1 = $urandom_range(0, CW - 1);
    p2 = (p1 + $urandom_range(1, CW - 1)) % CW;
    if (nf >= 1) m[p1] = 1'b1;
    if (nf >= 2) m[p2] = 1'b1;
    send_flip(8'($urandom), m);
  endtask

  task automatic send_sec();
    logic [CW-1:0] m;
    m = '0;
    m[$urandom_range(0, CW - 1)] = 1'b1;
    send_flip(8'($urandom), m);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", q.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, "_cnt_sec"}, 32'(cnt_sec), m_sec);
    chk({tag, "_cnt_ded"}, 32'(cnt_ded), m_ded);
  endtask

  task automatic clear_counts();
    cnt_clr = 1'b1;
    sync();
    cnt_clr = 1'b0;
    m_sec = 0;
    m_ded = 0;
  endtask

  // Monitor: scoreboard compare, stall-hold stability, in_ready rule.
  initial begin
    exp_t          e;
    logic          pv, ps, pd;
    logic [DW-1:0] pdat;
    bit            stall;
    stall = 0;
    pv = 0; ps = 0; pd = 0; pdat = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall = 0;
        continue;
      end
      chk("in_ready_rule", 32'(in_ready), 32'(!out_valid || out_ready));
      if (stall) begin
        chk("hold_valid", 32'(out_valid), 32'(pv));
        chk("hold_data",  32'(out_data),  32'(pdat));
        chk("hold_sec",   32'(out_sec),   32'(ps));
        chk("hold_ded",   32'(out_ded),   32'(pd));
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: data 0x%0h with empty scoreboard", out_data);
        end else begin
          e = q.pop_front();
          chk("out_data", 32'(out_data), 32'(e.data));
          chk("out_sec",  32'(out_sec),  32'(e.sec));
          chk("out_ded",  32'(out_ded),  32'(e.ded));
        end
      end
      stall = out_valid && !out_ready;
      pv = out_valid; ps = out_sec; pd = out_ded; pdat = out_data;
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    int c0;
    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data",  32'(out_data),  0);
    chk("rst_out_sec",   32'(out_sec),   0);
    chk("rst_out_ded",   32'(out_ded),   0);
    chk("rst_cnt_sec",   32'(cnt_sec),   0);
    chk("rst_cnt_ded",   32'(cnt_ded),   0);
    chk("rst_in_ready",  32'(in_ready),  1);
    rst_n = 1'b1;
    sync();

    // Clean zero codeword with latency check
    send_flip(8'h00, 13'h0000);
    @(negedge clk);
    chk("latency_c1_valid", 32'(out_valid), 0);
    @(negedge clk);
    chk("latency_c2_valid", 32'(out_valid), 1);
    drain();

    // Data bit 0 flipped (codeword 0x0004)
    send_flip(8'h00, 13'h0004);
    drain();
    chk_counts("sec1");

    // Two flips, syndrome 6 (codeword 0x0014), then overall parity flip (0x1000)
    send_flip(8'h00, 13'h0014);
    drain();
    chk_counts("ded1");
    send_flip(8'h00, 13'h1000);
    drain();
    chk_counts("parity_sec");

    // Stall: four back-to-back words, out_ready low for cycles 2-5
    fork
      begin
        send_flip(8'hA5, 13'h0000);
        send_flip(8'h3C, 13'h0100);
        send_flip(8'hF0, 13'h0041);
        send_flip(8'h81, 13'h0002);
      end
      begin
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk("stall_in_ready", 32'(in_ready), 0);
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Throughput: eight words in eight cycles with out_ready held high
    c0 = cycles;
    for (int i = 0; i < 8; i++) send_rand(2);
    chk("throughput_cycles", 32'(cycles - c0), 8);
    drain();

    // Saturation then clear-beats-increment
    clear_counts();
    chk_counts("clr");
    for (int i = 0; i < 9; i++) send_sec();
    drain();
    chk("sat_cnt_sec", 32'(cnt_sec), m_sec);
    send_sec();
    cnt_clr = 1'b1;
    sync();
    cnt_clr = 1'b0;
    m_sec = 0;
    m_ded = 0;
    chk("clr_wins_cnt_sec", 32'(cnt_sec), 0);
    drain();
    chk_counts("after_clr");

    // Reset mid-flight discards in-flight words
    out_ready = 1'b0;
    send_flip(8'h11, 13'h0000);
    send_flip(8'h22, 13'h0000);
    rst_n = 1'b0;
    q.delete();
    m_sec = 0;
    m_ded = 0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_in_ready",  32'(in_ready),  1);
    sync();
    rst_n = 1'b1;
    out_ready = 1'b1;
    sync();
    send_flip(8'h5A, 13'h0000);
    drain();
    chk_counts("midrst");

    // Random traffic with random backpressure
    clear_counts();
    rand_ready = 1;
    for (int i = 0; i < 6; i++) send_rand(2);
    drain();
    chk_counts("rand_small");
    for (int i = 0; i < 60; i++) send_rand(2);
    drain();
    rand_ready = 0;
    sync();
    out_ready = 1'b1;
    chk_counts("rand_big");

`ifdef ECC_ERR_INJECT_EN
    // One-shot injection hits only the first word after arming
    inj_arm  = 1'b1;
    inj_mask = 13'h0004;
    sync();
    inj_arm  = 1'b0;
    inj_mask = '0;
    send_raw(13'h0000, '{8'h00, 1'b1, 1'b0});
    send_raw(13'h0000, '{8'h00, 1'b0, 1'b0});
    drain();
`endif

    chk("scoreboard_empty", 32'(q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
